// File: rtl/cud_monitor.sv
// cud_monitor: passive reference-model checker for the WIDTH-bit up/down counter
module cud_monitor #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             chk_en,
    input  logic             clr,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load,
    input  logic             ud,
    input  logic [WIDTH-1:0] count,
    input  logic             rollover,
    output logic             mismatch,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] roll_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs
);
    typedef enum logic [1:0] {IDLE, RUN, FAIL} state_t;
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [ERR_W-1:0] SAT = '1;
    state_t           state;
    logic [WIDTH-1:0] exp_cnt, src, nxt;
    logic             exp_roll, nxt_roll, active, bad;
    // IDLE resyncs the model to the observed count every cycle
    assign src      = (state == IDLE) ? count : exp_cnt;
    assign nxt      = load_en ? load : ud ? src + 1'b1 : src - 1'b1;
    assign nxt_roll = !load_en && (ud ? src == MAX : src == '0);
    assign active   = state != IDLE;
    assign bad      = active && (count != exp_cnt || rollover != exp_roll);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_cnt   <= '0;
            exp_roll  <= 1'b0;
            state     <= IDLE;
            mismatch  <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= '0;
            roll_cnt  <= '0;
            first_exp <= '0;
            first_obs <= '0;
        end else begin
            exp_cnt  <= nxt;
            exp_roll <= nxt_roll;
            if (clr) begin
                state     <= IDLE;
                mismatch  <= 1'b0;
                fail      <= 1'b0;
                err_cnt   <= '0;
                roll_cnt  <= '0;
                first_exp <= '0;
                first_obs <= '0;
            end else begin
                state    <= bad || state == FAIL ? FAIL : chk_en ? RUN : IDLE;
                mismatch <= bad;
                if (bad && err_cnt != SAT)
                    err_cnt <= err_cnt + ERR_W'(1);
                if (active && exp_roll && roll_cnt != SAT)
                    roll_cnt <= roll_cnt + ERR_W'(1);
                if (bad && !fail) begin
                    fail      <= 1'b1;
                    first_exp <= exp_cnt;
                    first_obs <= count;
                end
            end
        end
    end
endmodule

// File: tb/tb_cud_monitor.sv
// tb_cud_monitor: directed bench driving a behavioural counter plus injected faults
module tb_cud_monitor;
    logic       clk = 1'b0;
    logic       rstn, chk_en, clr, load_en, ud, rollover;
    logic [3:0] load, count;
    logic       mismatch, fail;
    logic [7:0] err_cnt, roll_cnt;
    logic [3:0] first_exp, first_obs;
    logic [3:0] cs;
    logic       cr, seen;
    int         checks = 0;
    int         errors = 0;

    cud_monitor #(.WIDTH(4), .ERR_W(8)) dut (
        .clk(clk), .rstn(rstn), .chk_en(chk_en), .clr(clr),
        .load_en(load_en), .load(load), .ud(ud), .count(count),
        .rollover(rollover), .mismatch(mismatch), .fail(fail),
        .err_cnt(err_cnt), .roll_cnt(roll_cnt),
        .first_exp(first_exp), .first_obs(first_obs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock of a correct counter; callers may override count/rollover afterwards
    task automatic cyc(input logic le, input logic [3:0] ld, input logic u);
        load_en = le;
        load    = ld;
        ud      = u;
        @(posedge clk);
        #1;
        cr       = !le && (u ? cs == 4'd15 : cs == 4'd0);
        cs       = le ? ld : u ? cs + 4'd1 : cs - 4'd1;
        count    = cs;
        rollover = cr;
    endtask

    initial begin
        rstn = 1'b0; chk_en = 1'b0; clr = 1'b0; load_en = 1'b0; load = '0; ud = 1'b1;
        cs = '0; cr = 1'b0; count = '0; rollover = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mismatch", mismatch, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_roll_cnt", roll_cnt, 0);
        chk("rst_first_exp", first_exp, 0);
        chk("rst_first_obs", first_obs, 0);
        rstn = 1'b1;

        // 1: count up through one wrap
        chk_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1);
            seen |= mismatch;
        end
        chk("up_mismatch", seen, 0);
        chk("up_roll_cnt", roll_cnt, 1);
        chk("up_fail", fail, 0);

        // 2: count down through 0 -> 15 with rollover
        seen = 1'b0;
        repeat (6) begin
            cyc(0, 0, 0);
            seen |= mismatch;
        end
        chk("down_mismatch", seen, 0);
        chk("down_roll_cnt", roll_cnt, 2);
        chk("down_err_cnt", err_cnt, 0);

        // 3: count is 14; step down to 6 then inject 7
        repeat (8) cyc(0, 0, 0);
        count = 4'd7;
        #1;
        chk("inj_no_early", mismatch, 0);
        cyc(0, 0, 0);
        chk("inj_mismatch", mismatch, 1);
        chk("inj_fail", fail, 1);
        chk("inj_err_cnt", err_cnt, 1);
        chk("inj_first_exp", first_exp, 6);
        chk("inj_first_obs", first_obs, 7);
        cyc(0, 0, 0);
        chk("inj_pulse_end", mismatch, 0);
        count = 4'd9;
        cyc(0, 0, 0);
        chk("inj2_mismatch", mismatch, 1);
        chk("inj2_err_cnt", err_cnt, 2);
        chk("inj2_first_exp", first_exp, 6);
        chk("inj2_first_obs", first_obs, 7);
        clr = 1'b1;
        cyc(0, 0, 0);
        clr = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_fail", fail, 0);
        chk("clr_first_obs", first_obs, 0);
        chk("clr_roll_cnt", roll_cnt, 0);

        // 4: load 15 while up and exp=15; load wins, rollover must stay 0
        cyc(1, 4'd15, 1);
        cyc(1, 4'd15, 1);
        rollover = 1'b1;
        #1;
        chk("load_clean", mismatch, 0);
        cyc(0, 0, 1);
        chk("load_roll_flag", mismatch, 1);
        chk("load_first_exp", first_exp, 15);
        chk("load_first_obs", first_obs, 15);
        chk("load_err_cnt", err_cnt, 1);

        // 5: track-only jump to 9, then resume checking
        chk_en = 1'b0;
        clr = 1'b1;
        cyc(0, 0, 1);
        clr = 1'b0;
        cyc(0, 0, 1);
        cs = 4'd9;
        count = 4'd9;
        rollover = 1'b0;
        chk_en = 1'b1;
        cyc(0, 0, 1);
        chk("resync_count", count, 10);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("resync_mismatch", mismatch, 0);
        chk("resync_fail", fail, 0);
        chk("resync_err_cnt", err_cnt, 0);

        // 6: saturate err_cnt, clear, then async reset mid-run
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 1);
            count = ~cs;
        end
        cyc(0, 0, 1);
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_fail", fail, 1);
        clr = 1'b1;
        cyc(0, 0, 1);
        clr = 1'b0;
        chk("sat_clr_err", err_cnt, 0);
        chk("sat_clr_roll", roll_cnt, 0);
        chk("sat_clr_fail", fail, 0);
        chk("sat_clr_first_exp", first_exp, 0);
        repeat (2) cyc(0, 0, 1);
        count = cs + 4'd3;
        cyc(0, 0, 1);
        chk("pre_rst_fail", fail, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_mismatch", mismatch, 0);
        chk("arst_fail", fail, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_first_obs", first_obs, 0);
        cs = '0;
        count = '0;
        rollover = 1'b0;
        rstn = 1'b1;
        repeat (3) cyc(0, 0, 1);
        chk("post_rst_mismatch", mismatch, 0);
        chk("post_rst_fail", fail, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
